// File: rtl/ddr_app_pkg.sv
// ddr_app_pkg
// Shared definitions for the DDR3 app-interface link between the cache bridge
// and its responders: command codes, responder state encoding, the shift
// that turns a 16-bit-word app address into a 128-bit beat index, and the
// default port widths used on both sides of the link.
package ddr_app_pkg;

  localparam int DDR_TYPE_WIDTH = 3;
  localparam int DDR_ADDR_WIDTH = 27;
  localparam int DDR_BRST_WIDTH = 6;
  localparam int DDR_DATA_WIDTH = 128;
  localparam int DDR_MASK_WIDTH = DDR_DATA_WIDTH / 8;

  localparam logic [DDR_TYPE_WIDTH-1:0] DDR_WT_CMD = 3'd0;
  localparam logic [DDR_TYPE_WIDTH-1:0] DDR_RD_CMD = 3'd1;

  // One 128-bit beat covers eight 16-bit app address units.
  localparam int BEAT_SHIFT = 3;

  typedef enum logic [2:0] {
    ST_CALIB,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/ddr_app_bram_responder_if.sv
// ddr_app_bram_responder_if
// App-side command/write/read channel of the DDR3 controller user interface.
//   master : cache bridge (drives commands and write beats)
//   slave  : responder (drives readies, read beats and calibration status)
interface ddr_app_bram_responder_if #(
  parameter int ADDR_WIDTH = ddr_app_pkg::DDR_ADDR_WIDTH,
  parameter int BRST_WIDTH = ddr_app_pkg::DDR_BRST_WIDTH,
  parameter int DATA_WIDTH = ddr_app_pkg::DDR_DATA_WIDTH,
  parameter int MASK_WIDTH = ddr_app_pkg::DDR_MASK_WIDTH
);

  logic [BRST_WIDTH-1:0] io_app_burst_number;
  logic                  io_app_cmd_ready;
  logic [2:0]            io_app_cmd;
  logic                  io_app_cmd_en;
  logic [ADDR_WIDTH-1:0] io_app_addr;
  logic                  io_app_wdata_ready;
  logic [DATA_WIDTH-1:0] io_app_wdata;
  logic                  io_app_wdata_en;
  logic                  io_app_wdata_end;
  logic [MASK_WIDTH-1:0] io_app_wdata_mask;
  logic [DATA_WIDTH-1:0] io_app_rdata;
  logic                  io_app_rdata_valid;
  logic                  io_app_rdata_end;
  logic                  io_app_init_calib_complete;

  modport master (
    output io_app_burst_number, io_app_cmd, io_app_cmd_en, io_app_addr,
           io_app_wdata, io_app_wdata_en, io_app_wdata_end, io_app_wdata_mask,
    input  io_app_cmd_ready, io_app_wdata_ready, io_app_rdata,
           io_app_rdata_valid, io_app_rdata_end, io_app_init_calib_complete
  );

  modport slave (
    input  io_app_burst_number, io_app_cmd, io_app_cmd_en, io_app_addr,
           io_app_wdata, io_app_wdata_en, io_app_wdata_end, io_app_wdata_mask,
    output io_app_cmd_ready, io_app_wdata_ready, io_app_rdata,
           io_app_rdata_valid, io_app_rdata_end, io_app_init_calib_complete
  );

endinterface

// File: rtl/ddr_app_bram_responder_bram_be_sdp.sv
// bram_be_sdp
// Simple dual-port block RAM with per-byte write enables and a registered
// read port (one cycle from raddr_i/re_i to rdata_o). Contents are not reset.
//   clk      : clock
//   we_i     : per-byte write enables
//   waddr_i  : write beat index
//   wdata_i  : write beat
//   re_i     : read enable
//   raddr_i  : read beat index
//   rdata_o  : registered read beat
module bram_be_sdp
  import ddr_app_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int DATA_WIDTH = DDR_DATA_WIDTH,
  parameter int MASK_WIDTH = DDR_MASK_WIDTH
) (
  input  logic                  clk,
  input  logic [MASK_WIDTH-1:0] we_i,
  input  logic [MEM_AW-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [MEM_AW-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int BYTE_W = DATA_WIDTH / MASK_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-lane writes; lanes with a cleared enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < MASK_WIDTH; b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Registered read so the array maps onto block RAM output registers.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ddr_app_bram_responder.sv
// ddr_app_bram_responder
// BRAM-backed stand-in for the DDR3 controller app interface. After a fixed
// calibration delay it accepts write/read burst commands and services them
// from on-chip memory, returning read beats two cycles after issue.
//   clk      : controller-side clock
//   rstn     : asynchronous active-low reset
//   stall_i  : test backpressure, drops both readies and gaps read issue
//   err_o    : sticky protocol error (illegal cmd, misplaced/missing wdata_end)
//   app      : app command/write/read channel (slave side)
module ddr_app_bram_responder
  import ddr_app_pkg::*;
#(
  parameter int ADDR_WIDTH   = DDR_ADDR_WIDTH,
  parameter int BRST_WIDTH   = DDR_BRST_WIDTH,
  parameter int DATA_WIDTH   = DDR_DATA_WIDTH,
  parameter int MASK_WIDTH   = DDR_MASK_WIDTH,
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        stall_i,
  output logic                        err_o,
  ddr_app_bram_responder_if.slave     app
);

  localparam int CALIB_CNT_W = $clog2(CALIB_CYCLES + 1);

  state_e                  state_q;
  logic [CALIB_CNT_W-1:0]  calibCnt_q;
  logic                    calib_q;
  logic                    err_q;
  logic [MEM_AW-1:0]       startIdx_q;
  logic [BRST_WIDTH-1:0]   burst_q;
  logic [BRST_WIDTH-1:0]   beatCnt_q;
  logic                    issueValid_q;
  logic                    issueLast_q;
  logic                    rdataValid_q;
  logic                    rdataEnd_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [ADDR_WIDTH-1:0]   cmdBeat;
  logic [MEM_AW-1:0]       beatIdx;
  logic                    lastBeat;
  logic                    cmdFire;
  logic                    wrFire;
  logic                    rdIssue;
  logic [MASK_WIDTH-1:0]   byteWe;
  logic [DATA_WIDTH-1:0]   bramDout;
  logic                    unusedBits;

  // Beat index wraps silently modulo the BRAM depth; the upper address bits
  // beyond the BRAM are deliberately ignored.
  assign cmdBeat    = app.io_app_addr >> BEAT_SHIFT;
  assign unusedBits = ^cmdBeat[ADDR_WIDTH-1:MEM_AW];
  assign beatIdx    = startIdx_q + MEM_AW'(beatCnt_q);
  assign lastBeat   = (beatCnt_q == burst_q);

  assign cmdFire = (state_q == ST_IDLE)  && !stall_i && app.io_app_cmd_en;
  assign wrFire  = (state_q == ST_WRITE) && !stall_i && app.io_app_wdata_en;
  assign rdIssue = (state_q == ST_READ)  && !stall_i;
  assign byteWe  = {MASK_WIDTH{wrFire}} & ~app.io_app_wdata_mask;

  bram_be_sdp #(
    .MEM_AW     (MEM_AW),
    .DATA_WIDTH (DATA_WIDTH),
    .MASK_WIDTH (MASK_WIDTH)
  ) u_bram (
    .clk     (clk),
    .we_i    (byteWe),
    .waddr_i (beatIdx),
    .wdata_i (app.io_app_wdata),
    .re_i    (rdIssue),
    .raddr_i (beatIdx),
    .rdata_o (bramDout)
  );

  // Main control: calibration countdown, command accept, burst beat counting
  // and sticky error detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_CALIB;
      calibCnt_q <= '0;
      calib_q    <= 1'b0;
      err_q      <= 1'b0;
      startIdx_q <= '0;
      burst_q    <= '0;
      beatCnt_q  <= '0;
    end else begin
      case (state_q)
        ST_CALIB: begin
          if (calibCnt_q == CALIB_CNT_W'(CALIB_CYCLES - 1)) begin
            calib_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            calibCnt_q <= calibCnt_q + CALIB_CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (cmdFire) begin
            startIdx_q <= cmdBeat[MEM_AW-1:0];
            burst_q    <= app.io_app_burst_number;
            beatCnt_q  <= '0;
            case (app.io_app_cmd)
              DDR_WT_CMD: state_q <= ST_WRITE;
              DDR_RD_CMD: state_q <= ST_READ;
              default:    err_q   <= 1'b1;
            endcase
          end
        end
        ST_WRITE: begin
          if (wrFire) begin
            beatCnt_q <= beatCnt_q + BRST_WIDTH'(1);
            // The beat is committed either way; only the end strobe placement
            // is policed here.
            if (lastBeat) begin
              if (!app.io_app_wdata_end) err_q <= 1'b1;
              state_q <= ST_IDLE;
            end else if (app.io_app_wdata_end) begin
              err_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (rdIssue) begin
            beatCnt_q <= beatCnt_q + BRST_WIDTH'(1);
            if (lastBeat) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last beat sits in the output register during this cycle, so
          // returning to IDLE here leaves the pipeline empty.
          if (!issueValid_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_CALIB;
      endcase
    end
  end

  // Read return pipeline: issue flags ride alongside the BRAM output register,
  // then everything lands in the output register. Data is forced to zero on
  // idle cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issueValid_q <= 1'b0;
      issueLast_q  <= 1'b0;
      rdataValid_q <= 1'b0;
      rdataEnd_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      issueValid_q <= rdIssue;
      issueLast_q  <= rdIssue && lastBeat;
      rdataValid_q <= issueValid_q;
      rdataEnd_q   <= issueLast_q;
      rdata_q      <= issueValid_q ? bramDout : '0;
    end
  end

  assign app.io_app_cmd_ready           = (state_q == ST_IDLE)  && !stall_i;
  assign app.io_app_wdata_ready         = (state_q == ST_WRITE) && !stall_i;
  assign app.io_app_rdata               = rdata_q;
  assign app.io_app_rdata_valid         = rdataValid_q;
  assign app.io_app_rdata_end           = rdataEnd_q;
  assign app.io_app_init_calib_complete = calib_q;
  assign err_o                          = err_q;

endmodule

// File: doc/ddr_app_bram_responder.md
Name: ddr_app_bram_responder

Overview:
- Synthesizable stand-in for the DDR3 controller user ("app") interface, on the responder side of the link our cache bridge drives.
- Accepts app commands (write/read with burst count) and services them from an on-chip BRAM.
- Returns read beats with valid/end strobes and models calibration delay plus optional backpressure.
- Used in simulation and on FPGA builds without DDR3 to exercise the bridge and cache end to end.

Parameters:
ADDR_WIDTH, 27, app address width (16-bit word units)
BRST_WIDTH, 6, burst_number width; beats per command = burst_number+1 (1..64)
DATA_WIDTH, 128, beat width
MASK_WIDTH, 16, byte mask width (DATA_WIDTH/8)
MEM_AW, 10, log2 of BRAM depth in beats
CALIB_CYCLES, 64, cycles after reset before calibration completes

Ports:
clk  input  1  controller-side clock (100MHz domain)
rstn  input  1  reset; asynchronous, active-low
io_app_burst_number  input  BRST_WIDTH  beats-1 of command
io_app_cmd_ready  output  1  command accept
io_app_cmd  input  3  0=write, 1=read, others illegal
io_app_cmd_en  input  1  command valid
io_app_addr  input  ADDR_WIDTH  start address
io_app_wdata_ready  output  1  write beat accept
io_app_wdata  input  DATA_WIDTH  write beat
io_app_wdata_en  input  1  write beat valid
io_app_wdata_end  input  1  marks last write beat
io_app_wdata_mask  input  MASK_WIDTH  1 = byte NOT written
io_app_rdata  output  DATA_WIDTH  read beat
io_app_rdata_valid  output  1  read beat valid
io_app_rdata_end  output  1  last read beat
io_app_init_calib_complete  output  1  calibration done
stall_i  input  1  test backpressure; forces both readies low
err_o  output  1  sticky protocol error

Behaviour:
- Reset values: all outputs 0, state CALIB, counters 0. BRAM contents are not reset.
- CALIB: counter runs CALIB_CYCLES cycles, then calib_complete=1 (registered, stays 1 until reset), state -> IDLE.
- Beat index = io_app_addr[ADDR_WIDTH-1:3] + beat_cnt, taken modulo 2^MEM_AW. Wraps silently.
- IDLE: cmd_ready = !stall_i. A command fires on cmd_en && cmd_ready. On fire, latch cmd, addr, burst_number; beat_cnt=0.
  - cmd 0 -> WRITE.
  - cmd 1 -> READ.
  - Other values: set err_o, stay IDLE.
- WRITE: cmd_ready=0, wdata_ready=!stall_i.
  - Each beat fires on wdata_en && wdata_ready. Write BRAM with per-byte enable = ~mask; beat_cnt++.
  - Last beat: beat_cnt==burst_number.
    - wdata_end must be 1, else err_o. The write is still committed.
    - State -> IDLE, so cmd_ready may be 1 the next cycle.
  - wdata_end on a non-last beat: err_o, beat still written, burst continues.
  - wdata_en in IDLE/READ/CALIB: ignored, since ready=0.
- READ: cmd_ready=0, wdata_ready=0.
  - Issue one BRAM read per cycle unless stall_i. burst_number+1 reads total.
  - Fixed 2-cycle latency, issue to rdata_valid: registered BRAM output plus output register.
  - rdata_end=1 coincident with the final rdata_valid.
  - stall_i gaps reads and produces valid gaps. The master cannot backpressure.
  - After the last issue -> DRAIN. Once the pipeline is empty (after rdata_end cycle) -> IDLE.
- Read-after-write to the same address returns the new data; write completes before IDLE.
- rdata is 0 when rdata_valid=0.
- cmd_en while cmd_ready=0: ignored, no error. The master holds it until accepted.
- err_o is sticky until rstn.
- Async reset mid-burst: immediate return to CALIB; in-flight beats dropped; valid/end deasserted asynchronously.

Decomposition:
- Shared package ddr_app_pkg holds:
  - DDR_WT_CMD=3'd0, DDR_RD_CMD=3'd1
  - state encoding CALIB/IDLE/WRITE/READ/DRAIN
  - beat-to-address shift (3)
  - the same TYPE/ADDR/BRST/DATA/MASK width defaults used by the bridge
- One sub-module: bram_be_sdp — simple dual-port BRAM, MASK_WIDTH byte enables, registered read, depth 2^MEM_AW.

Test Plan:
- Reset, then count cycles -> calib_complete rises exactly 64 cycles after rstn release; cmd_ready=0 before, =1 the cycle after.
- Write addr=0x000010, burst_number=3, data 0xA0..0xA3, mask 0; then read the same -> 4 rdata_valid beats 0xA0..0xA3 starting 2 cycles after first issue, rdata_end on the 4th, err_o=0.
- Write mask 16'h00FF over existing 0xFFFF..FF, data 0 -> readback upper 8 bytes 0, lower 8 bytes 0xFF.
- Address wrap: addr=(1023<<3), burst_number=1 -> beats land at index 1023 and 0; readback from addr 0 returns the second beat.
- Protocol errors: wdata_end on beat 0 of 2-beat write -> err_o=1 and both beats still written; cmd=3'd5 -> err_o set, state IDLE.
- stall_i toggled every other cycle during a 64-beat read -> exactly 64 valid beats in order with gaps, single rdata_end; rstn pulse mid-burst -> valid drops at once, calib restarts.
